// File: rtl/scr1_dmi_chain_ctrl.sv
// SysCLK-domain DMI/DTMCS scan-chain controller: owns the chain shift register,
// sequences Debug Module accesses and tracks the DTM busy/error sticky status.
module scr1_dmi_chain_ctrl #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 32,
  parameter int IDLE_HINT = 1
) (
  input  logic              clk,
  input  logic              tapc_trst_n,
  input  logic              dmi_ch_sel_i,
  input  logic              ch_id_i,
  input  logic              ch_capture_i,
  input  logic              ch_shift_i,
  input  logic              ch_update_i,
  input  logic              ch_tdi_i,
  output logic              ch_tdo_o,
  output logic              dmi_req_o,
  output logic              dmi_wr_o,
  output logic [ADDR_W-1:0] dmi_addr_o,
  output logic [DATA_W-1:0] dmi_wdata_o,
  input  logic              dmi_req_ack_i,
  input  logic              dmi_resp_vld_i,
  input  logic [DATA_W-1:0] dmi_rdata_i,
  input  logic              dmi_resp_err_i,
  output logic              dmi_busy_o
);

  localparam int L = ADDR_W + DATA_W + 2;
  localparam logic [5:0] ADDR_W6 = 6'(ADDR_W);
  localparam logic [2:0] IDLE3   = 3'(IDLE_HINT);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t            r_state;
  logic [L-1:0]      r_sr;
  logic [1:0]        r_sticky;
  logic [ADDR_W-1:0] r_last_addr;
  logic [DATA_W-1:0] r_last_rdata;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wr;

  logic        w_busy;
  logic        w_upd;
  logic        w_cap;
  logic        w_shift;
  logic        w_hardrst;
  logic [1:0]  w_op;
  logic [1:0]  w_status;
  logic [31:0] w_dtmcs;

  // Strobe priority update > capture > shift, all gated by chain select
  assign w_upd     = dmi_ch_sel_i & ch_update_i;
  assign w_cap     = dmi_ch_sel_i & ~ch_update_i & ch_capture_i;
  assign w_shift   = dmi_ch_sel_i & ~ch_update_i & ~ch_capture_i & ch_shift_i;
  assign w_busy    = (r_state != ST_IDLE);
  assign w_op      = r_sr[1:0];
  assign w_hardrst = w_upd & ~ch_id_i & r_sr[17];
  assign w_status  = w_busy ? 2'd3 : r_sticky;
  assign w_dtmcs   = {14'b0, 2'b00, 1'b0, IDLE3, r_sticky, ADDR_W6, 4'h1};

  assign ch_tdo_o    = r_sr[0];
  assign dmi_req_o   = (r_state == ST_REQ);
  assign dmi_busy_o  = w_busy;
  assign dmi_wr_o    = r_wr;
  assign dmi_addr_o  = r_addr;
  assign dmi_wdata_o = r_wdata;

  always_ff @(posedge clk or negedge tapc_trst_n) begin
    if (!tapc_trst_n) begin
      r_state      <= ST_IDLE;
      r_sr         <= '0;
      r_sticky     <= '0;
      r_last_addr  <= '0;
      r_last_rdata <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wr         <= 1'b0;
    end else begin
      // DM handshake first; strobe handling below overrides state and sticky
      unique case (r_state)
        ST_REQ: if (dmi_req_ack_i) r_state <= ST_WAIT;
        ST_WAIT: begin
          if (dmi_resp_vld_i && !w_hardrst) begin
            r_state <= ST_IDLE;
            if (!r_wr) r_last_rdata <= dmi_rdata_i;
            if (dmi_resp_err_i && (r_sticky == 2'd0)) r_sticky <= 2'd2;
          end
        end
        default: ;
      endcase

      if (w_upd) begin
        if (ch_id_i) begin
          if (w_busy) begin
            r_sticky <= 2'd3;
          end else if ((r_sticky == 2'd0) && ((w_op == 2'd1) || (w_op == 2'd2))) begin
            r_state     <= ST_REQ;
            r_wr        <= (w_op == 2'd2);
            r_addr      <= r_sr[L-1:DATA_W+2];
            r_wdata     <= r_sr[DATA_W+1:2];
            r_last_addr <= r_sr[L-1:DATA_W+2];
          end
        end else if (w_hardrst) begin
          r_sticky <= 2'd0;
          r_state  <= ST_IDLE;
        end else if (r_sr[16]) begin
          r_sticky <= 2'd0;
        end
      end else if (w_cap) begin
        if (ch_id_i) begin
          r_sr <= {r_last_addr, r_last_rdata, w_status};
          if (w_busy) r_sticky <= 2'd3;
        end else begin
          r_sr[31:0] <= w_dtmcs;
        end
      end else if (w_shift) begin
        if (ch_id_i) r_sr       <= {ch_tdi_i, r_sr[L-1:1]};
        else         r_sr[31:0] <= {ch_tdi_i, r_sr[31:1]};
      end
    end
  end

endmodule
